// File: rtl/write_trace_fifo_if.sv
// Write-trace bundle: core write events in, buffered trace entries out.
// The FIFO side uses slave; the producer/consumer side uses master.
interface write_trace_fifo_if #(
  parameter int DEPTH = 8
);
  logic [31:0]              pc;
  logic                     grf_we;
  logic [4:0]               grf_addr;
  logic [31:0]              grf_wdata;
  logic                     dm_we;
  logic [31:0]              dm_addr;
  logic [31:0]              dm_wdata;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_type;
  logic [31:0]              out_pc;
  logic [31:0]              out_addr;
  logic [31:0]              out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [15:0]              drop_cnt;

  modport master (
    output pc, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, out_ready,
    input  out_valid, out_type, out_pc, out_addr, out_data, count, overflow, drop_cnt
  );

  modport slave (
    input  pc, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, out_ready,
    output out_valid, out_type, out_pc, out_addr, out_data, count, overflow, drop_cnt
  );
endinterface

// File: rtl/write_trace_fifo.sv
// Buffers GRF-write / DM-store events in order for a valid/ready trace consumer.
// Latency: an event captured at one edge reaches the head after that edge; no input-to-output path.
// Backpressure: a stalled consumer fills the queue; excess events are dropped, counted and flagged.
module write_trace_fifo #(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  write_trace_fifo_if.slave tr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic [15:0]     drops;

  logic            pop;
  logic            grf_ev;
  logic            dm_ev;
  logic            grf_acc;
  logic            dm_acc;
  logic [CW-1:0]   free;
  logic [1:0]      n_acc;
  logic [1:0]      n_drop;
  logic [AW-1:0]   dm_slot;
  logic [16:0]     drop_sum;
  entry_t          grf_ent;
  entry_t          dm_ent;
  entry_t          head;

  always_comb begin
    pop     = (cnt != '0) && tr.out_ready;
    free    = CW'(DEPTH) - cnt + {{(CW-1){1'b0}}, pop};
    grf_ev  = tr.grf_we && (tr.grf_addr != 5'd0);
    dm_ev   = tr.dm_we;
    // GRF claims the first free slot; DM needs a second one when GRF was accepted
    grf_acc = grf_ev && (free != '0);
    dm_acc  = dm_ev && (grf_acc ? (free >= CW'(2)) : (free != '0));
    n_acc   = {1'b0, grf_acc} + {1'b0, dm_acc};
    n_drop  = {1'b0, grf_ev && !grf_acc} + {1'b0, dm_ev && !dm_acc};
    dm_slot = grf_acc ? (wptr + AW'(1)) : wptr;
    drop_sum = {1'b0, drops} + {15'd0, n_drop};

    grf_ent.typ  = 1'b0;
    grf_ent.pc   = tr.pc;
    grf_ent.addr = {27'd0, tr.grf_addr};
    grf_ent.data = tr.grf_wdata;
    dm_ent.typ   = 1'b1;
    dm_ent.pc    = tr.pc;
    dm_ent.addr  = tr.dm_addr;
    dm_ent.data  = tr.dm_wdata;

    head = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      drops <= 16'd0;
    end else begin
      wptr <= wptr + AW'(n_acc);
      rptr <= rptr + AW'(pop);
      cnt  <= cnt + CW'(n_acc) - CW'(pop);
      if (n_drop != 2'd0) begin
        ovf <= 1'b1;
      end
      drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Storage is not cleared; the reset count/pointers make stale entries unreachable
  always_ff @(posedge clk) begin
    if (reset) begin
      if (grf_acc) begin
        mem[wptr] <= grf_ent;
      end
      if (dm_acc) begin
        mem[dm_slot] <= dm_ent;
      end
    end
  end

  always_comb begin
    tr.out_valid = (cnt != '0);
    tr.out_type  = 1'b0;
    tr.out_pc    = 32'd0;
    tr.out_addr  = 32'd0;
    tr.out_data  = 32'd0;
    if (cnt != '0) begin
      tr.out_type = head.typ;
      tr.out_pc   = head.pc;
      tr.out_addr = head.addr;
      tr.out_data = head.data;
    end
    tr.count    = cnt;
    tr.overflow = ovf;
    tr.drop_cnt = drops;
  end
endmodule
